// File: rtl/io_output_reg.sv
// ============================================================================
// Module  : io_output_reg
// Brief   : Memory-mapped output ports with pending/ack handshake and overrun.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module io_output_reg #(
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        write_io_enable,
  input  logic [2:0]  ack,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [2:0]  pend,
  output logic [31:0] io_read_data
);

  localparam logic [5:0] C_SEL_PORT0  = 6'b100000;
  localparam logic [5:0] C_SEL_PORT1  = 6'b100001;
  localparam logic [5:0] C_SEL_PORT2  = 6'b100010;
  localparam logic [5:0] C_SEL_STATUS = 6'b100011;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } pend_state_t;

  logic [5:0]       w_sel;
  logic [2:0]       w_wr_port;
  logic             w_wr_status;
  logic [2:0]       w_ovr_set;
  logic [2:0]       w_ovr_clr;
  logic [2:0][31:0] r_port;
  logic [2:0]       r_ovr;

  assign w_sel        = addr[7:2];
  assign w_wr_port[0] = write_io_enable && (w_sel == C_SEL_PORT0);
  assign w_wr_port[1] = write_io_enable && (w_sel == C_SEL_PORT1);
  assign w_wr_port[2] = write_io_enable && (w_sel == C_SEL_PORT2);
  assign w_wr_status  = write_io_enable && (w_sel == C_SEL_STATUS);

  // A write that lands on a still-pending port with no ack loses the old value.
  assign w_ovr_set = w_wr_port & pend & ~ack;
  assign w_ovr_clr = {3{w_wr_status}} & datain[5:3];

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      r_port <= {3{RST_VAL}};
      r_ovr  <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_wr_port[i]) begin
          r_port[i] <= datain;
        end
        if (w_ovr_set[i]) begin
          r_ovr[i] <= 1'b1;
        end else if (w_ovr_clr[i]) begin
          r_ovr[i] <= 1'b0;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pend
      pend_state_t r_state;
      pend_state_t w_state_nxt;

      always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
          r_state <= ST_IDLE;
        end else begin
          r_state <= w_state_nxt;
        end
      end

      // A write in the same cycle as ack keeps the flag set.
      always_comb begin
        w_state_nxt = r_state;
        case (r_state)
          ST_IDLE: if (w_wr_port[gi]) w_state_nxt = ST_PEND;
          ST_PEND: if (!w_wr_port[gi] && ack[gi]) w_state_nxt = ST_IDLE;
          default: w_state_nxt = ST_IDLE;
        endcase
      end

      assign pend[gi] = (r_state == ST_PEND);
    end
  endgenerate

  always_comb begin
    io_read_data = 32'h0000_0000;
    case (w_sel)
      C_SEL_PORT0:  io_read_data = r_port[0];
      C_SEL_PORT1:  io_read_data = r_port[1];
      C_SEL_PORT2:  io_read_data = r_port[2];
      C_SEL_STATUS: io_read_data = {26'b0, r_ovr, pend};
      default:      io_read_data = 32'h0000_0000;
    endcase
  end

  assign out_port0 = r_port[0];
  assign out_port1 = r_port[1];
  assign out_port2 = r_port[2];

endmodule

`default_nettype wire
